// File: rtl/dcache_meta_pkg.sv
// dcache_meta_pkg: shared sizes, coherence encodings and entry layout for the metadata sink
package dcache_meta_pkg;
    localparam int N_SETS       = 64;
    localparam int IDX_W        = 6;
    localparam int TAG_W        = 20;
    localparam int STARVE_LIMIT = 4;
    typedef enum logic [1:0] {
        COH_NOTHING = 2'd0,
        COH_BRANCH  = 2'd1,
        COH_TRUNK   = 2'd2,
        COH_DIRTY   = 2'd3
    } coh_t;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef struct packed {
        logic [1:0]       coh_state;
        logic [TAG_W-1:0] tag;
    } meta_entry_t;
endpackage

// File: rtl/dcache_meta_write_sink_if.sv
// dcache_meta_write_sink_if: write request, read request/response and init status bundle
interface dcache_meta_write_sink_if;
    import dcache_meta_pkg::*;
    logic             io_req_ready;
    logic             io_req_valid;
    logic [IDX_W-1:0] io_req_bits_idx;
    logic             io_req_bits_way_en;
    logic [TAG_W-1:0] io_req_bits_tag;
    logic [1:0]       io_req_bits_data_coh_state;
    logic [TAG_W-1:0] io_req_bits_data_tag;
    logic             io_read_ready;
    logic             io_read_valid;
    logic [IDX_W-1:0] io_read_bits_idx;
    logic             io_resp_valid;
    logic [1:0]       io_resp_bits_coh_state;
    logic [TAG_W-1:0] io_resp_bits_tag;
    logic             io_init_done;
    modport master (
        input  io_req_ready, io_read_ready, io_resp_valid, io_resp_bits_coh_state,
               io_resp_bits_tag, io_init_done,
        output io_req_valid, io_req_bits_idx, io_req_bits_way_en, io_req_bits_tag,
               io_req_bits_data_coh_state, io_req_bits_data_tag, io_read_valid, io_read_bits_idx
    );
    modport slave (
        output io_req_ready, io_read_ready, io_resp_valid, io_resp_bits_coh_state,
               io_resp_bits_tag, io_init_done,
        input  io_req_valid, io_req_bits_idx, io_req_bits_way_en, io_req_bits_tag,
               io_req_bits_data_coh_state, io_req_bits_data_tag, io_read_valid, io_read_bits_idx
    );
endinterface

// File: rtl/dcache_meta_store.sv
// dcache_meta_store: register-array metadata store, one write port, one registered read port
module dcache_meta_store
    import dcache_meta_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  meta_entry_t      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic             o_rvalid,
    output meta_entry_t      o_rdata
);
    meta_entry_t r_mem [N_SETS];
    logic        r_rvalid;
    meta_entry_t r_rdata;
    // contents are cleared by the owner's init sweep, so the array itself has no reset
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= i_re;
            if (i_re) r_rdata <= r_mem[i_raddr];
        end
    end
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
endmodule

// File: rtl/dcache_meta_write_sink.sv
// dcache_meta_write_sink: clears the metadata store after reset, then arbitrates
// reads (priority) against writes with a bounded write-starvation counter.
module dcache_meta_write_sink
    import dcache_meta_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    dcache_meta_write_sink_if.slave   bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_init_cnt;
    logic [SW-1:0]    r_starve;
    logic             w_run, w_write_prio, w_req_fire, w_read_fire, w_we;
    logic [IDX_W-1:0] w_waddr;
    meta_entry_t      w_wdata, w_rdata;
    logic             w_rvalid;
    logic             w_unused_tag;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_starve   <= '0;
        end else begin
            r_state    <= w_next;
            r_init_cnt <= (r_state == ST_INIT) ? r_init_cnt + 1'b1 : r_init_cnt;
            r_starve   <= (bus.io_req_valid && !bus.io_req_ready) ?
                          (w_write_prio ? r_starve : r_starve + 1'b1) : '0;
        end
    end
    always_comb begin
        w_next = (r_state == ST_INIT && r_init_cnt == IDX_W'(N_SETS - 1)) ? ST_RUN : r_state;
    end
    always_comb begin
        w_run                      = (r_state == ST_RUN);
        w_write_prio               = (r_starve == STARVE_MAX);
        bus.io_read_ready          = w_run && (!w_write_prio || !bus.io_req_valid);
        bus.io_req_ready           = w_run && (w_write_prio || !bus.io_read_valid);
        bus.io_init_done           = w_run;
        w_req_fire                 = bus.io_req_valid && bus.io_req_ready;
        w_read_fire                = bus.io_read_valid && bus.io_read_ready;
        w_we                       = !w_run || (w_req_fire && bus.io_req_bits_way_en);
        w_waddr                    = w_run ? bus.io_req_bits_idx : r_init_cnt;
        w_wdata                    = w_run ? {bus.io_req_bits_data_coh_state, bus.io_req_bits_data_tag} : '0;
        bus.io_resp_valid          = w_rvalid;
        bus.io_resp_bits_coh_state = w_rdata.coh_state;
        bus.io_resp_bits_tag       = w_rdata.tag;
        w_unused_tag               = ^bus.io_req_bits_tag;
    end
    dcache_meta_store u_store (
        .clock    (clock),
        .reset    (reset),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_re     (w_read_fire),
        .i_raddr  (bus.io_read_bits_idx),
        .o_rvalid (w_rvalid),
        .o_rdata  (w_rdata)
    );
endmodule

// File: tb/tb_dcache_meta_write_sink.sv
// tb_dcache_meta_write_sink: directed scenario bench for the metadata write sink
module tb_dcache_meta_write_sink;
    import dcache_meta_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    dcache_meta_write_sink_if bus ();
    dcache_meta_write_sink dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic idle();
        bus.io_req_valid               = 1'b0;
        bus.io_req_bits_idx            = '0;
        bus.io_req_bits_way_en         = 1'b0;
        bus.io_req_bits_tag            = '0;
        bus.io_req_bits_data_coh_state = '0;
        bus.io_req_bits_data_tag       = '0;
        bus.io_read_valid              = 1'b0;
        bus.io_read_bits_idx           = '0;
    endtask
    task automatic wr(input logic [IDX_W-1:0] idx, input logic way, input logic [1:0] coh,
                      input logic [TAG_W-1:0] tag);
        bus.io_req_valid               = 1'b1;
        bus.io_req_bits_idx            = idx;
        bus.io_req_bits_way_en         = way;
        bus.io_req_bits_tag            = tag ^ 20'hFFFFF;
        bus.io_req_bits_data_coh_state = coh;
        bus.io_req_bits_data_tag       = tag;
        step();
        bus.io_req_valid       = 1'b0;
        bus.io_req_bits_way_en = 1'b0;
    endtask
    task automatic rd(input logic [IDX_W-1:0] idx, output logic v, output logic [1:0] c,
                      output logic [TAG_W-1:0] t);
        bus.io_read_valid    = 1'b1;
        bus.io_read_bits_idx = idx;
        step();
        bus.io_read_valid = 1'b0;
        v = bus.io_resp_valid;
        c = bus.io_resp_bits_coh_state;
        t = bus.io_resp_bits_tag;
    endtask
    task automatic wait_init(input string tag);
        logic bad_ready = 1'b0;
        logic bad_done  = 1'b0;
        for (int i = 1; i <= N_SETS; i++) begin
            step();
            if (i < N_SETS && (bus.io_req_ready || bus.io_read_ready || bus.io_resp_valid)) bad_ready = 1'b1;
            if (i < N_SETS && bus.io_init_done) bad_done = 1'b1;
        end
        n_checks += 3;
        if (bad_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_in_init got=%b exp=0", tag, bad_ready); end
        if (bad_done !== 1'b0) begin n_fail++; $display("FAIL %s_early_done got=%b exp=0", tag, bad_done); end
        if (bus.io_init_done !== 1'b1) begin n_fail++; $display("FAIL %s_done_at_64 got=%b exp=1", tag, bus.io_init_done); end
    endtask
    task automatic test_reset();
        logic v; logic [1:0] c; logic [TAG_W-1:0] t;
        idle();
        reset = 1'b1;
        repeat (3) step();
        n_checks += 5;
        if (bus.io_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", bus.io_resp_valid); end
        if (bus.io_resp_bits_coh_state !== 2'd0 || bus.io_resp_bits_tag !== 20'd0) begin
            n_fail++; $display("FAIL rst_resp_bits got=%h/%h exp=0/0", bus.io_resp_bits_coh_state, bus.io_resp_bits_tag);
        end
        if (bus.io_init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done got=%b exp=0", bus.io_init_done); end
        if (bus.io_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0", bus.io_req_ready); end
        if (bus.io_read_ready !== 1'b0) begin n_fail++; $display("FAIL rst_read_ready got=%b exp=0", bus.io_read_ready); end
        reset = 1'b0;
        bus.io_read_valid    = 1'b1;
        bus.io_read_bits_idx = 6'd37;
        wait_init("init1");
        bus.io_read_valid = 1'b0;
        rd(6'd37, v, c, t);
        n_checks += 2;
        if (v !== 1'b1) begin n_fail++; $display("FAIL rd37_valid got=%b exp=1", v); end
        if (c !== 2'd0 || t !== 20'd0) begin n_fail++; $display("FAIL rd37_data got=%h/%h exp=0/0", c, t); end
        step();
        n_checks++;
        if (bus.io_resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_valid_drop got=%b exp=0", bus.io_resp_valid); end
    endtask
    task automatic test_write_read();
        logic v; logic [1:0] c; logic [TAG_W-1:0] t;
        wr(6'd5, 1'b1, 2'd3, 20'hABCDE);
        rd(6'd5, v, c, t);
        n_checks += 2;
        if (v !== 1'b1) begin n_fail++; $display("FAIL rd5_valid got=%b exp=1", v); end
        if (c !== 2'd3 || t !== 20'hABCDE) begin n_fail++; $display("FAIL rd5_data got=%h/%h exp=3/abcde", c, t); end
        wr(6'd5, 1'b0, 2'd1, 20'h12345);
        rd(6'd5, v, c, t);
        n_checks++;
        if (c !== 2'd3 || t !== 20'hABCDE) begin n_fail++; $display("FAIL way_en0_drop got=%h/%h exp=3/abcde", c, t); end
    endtask
    task automatic test_starvation();
        bus.io_read_valid              = 1'b1;
        bus.io_read_bits_idx           = 6'd0;
        bus.io_req_valid               = 1'b1;
        bus.io_req_bits_idx            = 6'd9;
        bus.io_req_bits_way_en         = 1'b1;
        bus.io_req_bits_data_coh_state = 2'd2;
        bus.io_req_bits_data_tag       = 20'h11111;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_checks += 2;
            if (bus.io_req_ready !== (k == 5)) begin
                n_fail++; $display("FAIL starve_req_ready_c%0d got=%b exp=%b", k, bus.io_req_ready, k == 5);
            end
            if (bus.io_read_ready !== (k != 5)) begin
                n_fail++; $display("FAIL starve_read_ready_c%0d got=%b exp=%b", k, bus.io_read_ready, k != 5);
            end
            step();
        end
        bus.io_req_valid         = 1'b0;
        bus.io_req_bits_way_en   = 1'b0;
        bus.io_read_bits_idx     = 6'd9;
        #1;
        n_checks += 2;
        if (bus.io_read_ready !== 1'b1) begin n_fail++; $display("FAIL starve_resume got=%b exp=1", bus.io_read_ready); end
        if (bus.io_resp_valid !== 1'b0) begin n_fail++; $display("FAIL starve_no_resp got=%b exp=0", bus.io_resp_valid); end
        step();
        bus.io_read_valid = 1'b0;
        n_checks++;
        if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits_coh_state !== 2'd2 || bus.io_resp_bits_tag !== 20'h11111) begin
            n_fail++; $display("FAIL starve_commit got=%b/%h/%h exp=1/2/11111", bus.io_resp_valid,
                               bus.io_resp_bits_coh_state, bus.io_resp_bits_tag);
        end
    endtask
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            bus.io_req_valid               = 1'b1;
            bus.io_req_bits_idx            = 6'(i);
            bus.io_req_bits_way_en         = 1'b1;
            bus.io_req_bits_data_coh_state = 2'(i);
            bus.io_req_bits_data_tag       = 20'hA0000 + 20'(i);
            #1;
            n_checks++;
            if (bus.io_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready_%0d got=%b exp=1", i, bus.io_req_ready); end
            step();
        end
        bus.io_req_valid       = 1'b0;
        bus.io_req_bits_way_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.io_read_valid    = 1'b1;
            bus.io_read_bits_idx = 6'(i);
            step();
            n_checks++;
            if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits_coh_state !== 2'(i) ||
                bus.io_resp_bits_tag !== 20'hA0000 + 20'(i)) begin
                n_fail++; $display("FAIL b2b_read_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.io_resp_valid,
                                   bus.io_resp_bits_coh_state, bus.io_resp_bits_tag, 2'(i), 20'hA0000 + 20'(i));
            end
        end
        bus.io_read_valid = 1'b0;
    endtask
    task automatic test_reset_mid_op();
        logic v; logic [1:0] c; logic [TAG_W-1:0] t;
        wr(6'd7, 1'b1, 2'd2, 20'h77777);
        repeat (9) step();
        bus.io_read_valid    = 1'b1;
        bus.io_read_bits_idx = 6'd7;
        step();
        bus.io_read_valid = 1'b0;
        reset = 1'b1;
        n_checks++;
        if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits_coh_state !== 2'd2) begin
            n_fail++; $display("FAIL pre_rst_resp got=%b/%h exp=1/2", bus.io_resp_valid, bus.io_resp_bits_coh_state);
        end
        step();
        n_checks += 3;
        if (bus.io_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_resp_valid got=%b exp=0", bus.io_resp_valid); end
        if (bus.io_init_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_init_done got=%b exp=0", bus.io_init_done); end
        if (bus.io_read_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_read_ready got=%b exp=0", bus.io_read_ready); end
        reset = 1'b0;
        wait_init("init2");
        rd(6'd7, v, c, t);
        n_checks++;
        if (v !== 1'b1 || c !== 2'd0 || t !== 20'd0) begin
            n_fail++; $display("FAIL rd7_cleared got=%b/%h/%h exp=1/0/0", v, c, t);
        end
    endtask
    initial begin
        test_reset();
        test_write_read();
        test_starvation();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_meta_write_sink.md
Name: dcache_meta_write_sink

Overview:
- Consumer end of the two-way data-cache metadata write arbitration path.
- Accepts one arbitrated write per cycle (set index, way enable, tag, coherence state) over a valid/ready handshake and commits it into a per-set metadata store.
- Provides a 1-cycle-latency read port for lookup logic.
- Clears the store after reset.
- Arbitrates between reads and writes with read priority, bounded by a write anti-starvation counter.

Parameters:
- N_SETS, 64, number of metadata sets (power of two).
- IDX_W, 6, log2(N_SETS).
- TAG_W, 20, tag width.
- STARVE_LIMIT, 4, consecutive read-blocked cycles after which a pending write wins.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- io_req_ready  out  1  write accepted this cycle.
- io_req_valid  in  1  write request present.
- io_req_bits_idx  in  IDX_W  target set.
- io_req_bits_way_en  in  1  way enable; 0 means accept and drop (no store update).
- io_req_bits_tag  in  TAG_W  request tag (informational; not stored).
- io_req_bits_data_coh_state  in  2  coherence state to store.
- io_req_bits_data_tag  in  TAG_W  tag to store.
- io_read_ready  out  1  read accepted this cycle.
- io_read_valid  in  1  read request present.
- io_read_bits_idx  in  IDX_W  set to read.
- io_resp_valid  out  1  read data valid (1 cycle after read fire).
- io_resp_bits_coh_state  out  2  stored state.
- io_resp_bits_tag  out  TAG_W  stored tag.
- io_init_done  out  1  high once clearing is complete.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset values:
  - FSM=INIT, init counter=0, starve counter=0.
  - io_resp_valid=0, io_resp_bits_*=0, io_init_done=0.
  - io_req_ready=0, io_read_ready=0.
- Store: N_SETS entries of {coh_state[1:0], tag[TAG_W-1:0]}, register-based.
- FSM states:
  - INIT: each cycle writes entry[cnt] = {0,0}, then cnt++.
    - When cnt==N_SETS-1 is written, go to RUN next cycle; io_init_done=1 from that cycle onward.
    - INIT lasts exactly N_SETS cycles.
    - Both ready outputs are 0 in INIT.
  - RUN: remains in RUN until reset. No other exits.
- Priority in RUN:
  - write_prio = (starve_cnt == STARVE_LIMIT).
  - io_read_ready = ~write_prio | ~io_req_valid.
  - io_req_ready = write_prio | ~io_read_valid.
  - Both readies may be 1 only when at most one side is valid, so read fire and write fire never coincide.
- Starve counter:
  - If io_req_valid & ~io_req_ready: increment, saturating at STARVE_LIMIT.
  - Else if write fires: reset to 0.
  - If io_req_valid is low: hold at 0.
- Write fire (valid & ready):
  - If way_en=1, the entry at idx takes {data_coh_state, data_tag} at the clock edge.
  - If way_en=0, the handshake completes with no update.
- Read fire:
  - Next cycle io_resp_valid=1 and resp bits = entry contents at the fire edge.
  - A write fired in cycle N is visible to a read fired in cycle N+1 or later.
  - io_resp_valid is 0 in any cycle not following a read fire.
  - resp bits hold their last value when io_resp_valid=0.
- Handshake rule: ready never depends on valid of the same channel. Ready depends on the other channel's valid and on FSM state only.
- Reset mid-operation:
  - The next cycle is INIT with counter 0, io_resp_valid=0, starve=0, and all entries re-cleared over N_SETS cycles.
  - Any in-flight read response is discarded.
- Index arithmetic: idx used modulo N_SETS (exact width, no out-of-range). Init counter is IDX_W+1 bits or compared at N_SETS-1.

Decomposition:
- Shared package dcache_meta_pkg:
  - N_SETS, IDX_W, TAG_W, coh state encodings (Nothing=0, Branch=1, Trunk=2, Dirty=3).
  - meta_entry_t {coh_state, tag}.
- One natural sub-module: dcache_meta_store. It holds the register array with one write port and one registered read port.
- The top holds the INIT/RUN FSM, the starvation counter and the ready logic.

Test Plan:
- Reset for 3 cycles, then release:
  - io_init_done rises exactly 64 cycles after reset deasserts.
  - Readies are 0 throughout INIT.
  - A read of idx 37 then returns coh=0, tag=0 with io_resp_valid one cycle later.
- Write idx=5, way_en=1, coh=3, data_tag=0xABCDE; read idx 5 the next cycle:
  - Response one cycle later gives coh=3, tag=0xABCDE.
  - Write with way_en=0 to idx 5 (coh=1): a read still returns coh=3.
- Hold io_read_valid=1 continuously with a pending write (idx 9, coh=2):
  - io_req_ready=0 for 4 cycles, then 1 in the 5th, when io_read_ready=0.
  - Write commits.
  - Starve counter returns to 0 and reads resume the next cycle.
- Back-to-back writes: idx 0..3, one per cycle, with no reads:
  - io_req_ready constantly 1.
  - Subsequent reads 0..3 return written values with 1-cycle latency each.
- Assert reset 10 cycles after writing idx 7 (coh=2), while a read is in flight:
  - io_resp_valid=0 the cycle after reset.
  - INIT repeats for 64 cycles.
  - A read of idx 7 afterwards returns coh=0, tag=0.
